// File: rtl/u_result_stage.sv
// u_result_stage: registered writeback-result stage for LUI / AUIPC / JAL / JALR.
// Forms the destination-register value from U_control and buffers it in a
// two-entry skid buffer with valid/ready on both sides.
// Optional feature: define U_RESULT_STATS_EN to add per-kind result counters
// (cnt_lui, cnt_auipc, cnt_link).
//
//  state | meaning
//  ------+------------------------------------------------
//  EMPTY | no buffered result, outputs not valid
//  ONE   | head holds one result, tail unused
//  FULL  | head and tail both hold results, in_ready low
module u_result_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      U_control,
  input  logic            is_jump,
  input  logic [XLEN-1:0] pc,
  input  logic [19:0]     imm20,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_en,
  output logic            illegal
`ifdef U_RESULT_STATS_EN
  ,
  output logic [31:0]     cnt_lui,
  output logic [31:0]     cnt_auipc,
  output logic [31:0]     cnt_link
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            en;
    logic            ill;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, tail_q, new_e;
  logic   in_xfer, out_xfer;
  logic   load_head_new, load_tail_new, promote_tail;
  logic [XLEN-1:0] imm_sh;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign wb_data = head_q.data;
  assign wb_rd   = head_q.rd;
  assign wb_en   = head_q.en;
  assign illegal = head_q.ill;

  assign imm_sh = {imm20, 12'b0};

  // Result formation for the instruction currently offered upstream.
  always_comb begin
    new_e      = '0;
    new_e.rd   = rd;
    case (U_control)
      2'b01: begin
        new_e.data = imm_sh;
        new_e.en   = 1'b1;
      end
      2'b10: begin
        new_e.data = pc + imm_sh;
        new_e.en   = 1'b1;
      end
      2'b00: begin
        if (is_jump) begin
          new_e.data = pc + XLEN'(4);
          new_e.en   = 1'b1;
        end
      end
      default: begin
        new_e.ill = 1'b1;
      end
    endcase
    // x0 is never written, but the value is still carried for visibility.
    if (rd == 5'd0) new_e.en = 1'b0;
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy and entry-movement controls.
  always_comb begin
    state_d       = state_q;
    load_head_new = 1'b0;
    load_tail_new = 1'b0;
    promote_tail  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_head_new = 1'b1;
          state_d       = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_new = 1'b1;
        end else if (in_xfer) begin
          load_tail_new = 1'b1;
          state_d       = FULL;
        end else if (out_xfer) begin
          state_d       = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          promote_tail = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Entry storage: head drives the outputs, tail is promoted on head consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_new)     head_q <= new_e;
      else if (promote_tail) head_q <= tail_q;
      if (load_tail_new)     tail_q <= new_e;
    end
  end

`ifdef U_RESULT_STATS_EN
  logic [1:0] head_kind_q, tail_kind_q;

  // Result kind tracked alongside each entry so counters see what leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_kind_q <= 2'b00;
      tail_kind_q <= 2'b00;
    end else begin
      if (load_head_new)     head_kind_q <= U_control;
      else if (promote_tail) head_kind_q <= tail_kind_q;
      if (load_tail_new)     tail_kind_q <= U_control;
    end
  end

  // Count written results by kind; a written kind-00 entry is always a link.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lui   <= '0;
      cnt_auipc <= '0;
      cnt_link  <= '0;
    end else if (out_xfer && head_q.en) begin
      case (head_kind_q)
        2'b01:   cnt_lui   <= cnt_lui + 32'd1;
        2'b10:   cnt_auipc <= cnt_auipc + 32'd1;
        2'b00:   cnt_link  <= cnt_link + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule
